// File: rtl/controle_ula_pkg.sv
// Shared definitions for the ALU request sequencer: state encoding, default
// parameters and the opcode constants also used by the result-mux tree.
package controle_ula_pkg;

  localparam int DEF_WIDTH   = 4;
  localparam int DEF_OP_BITS = 3;
  localparam int DEF_NUM_OPS = 8;
  localparam int DEF_SETTLE  = 1;

  // Encoding 2'd3 is unreachable; the next-state logic steers it back to OCIOSO.
  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    ESPERA  = 2'd1,
    ENTREGA = 2'd2
  } estado_t;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_SLT  = 3'd5;
  localparam logic [2:0] OP_NOR  = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

endpackage

// File: rtl/controle_ula_contador.sv
// contador_espera: 4-bit loadable down-counter that stops at zero and
// flags when it has reached zero.
module contador_espera (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 4'd1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/controle_ula.sv
// controle_ula: accepts one ALU request, holds operands/select stable for
// SETTLE cycles, captures the mux-tree result and hands it downstream.
module controle_ula
  import controle_ula_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int OP_BITS = DEF_OP_BITS,
  parameter int NUM_OPS = DEF_NUM_OPS,
  parameter int SETTLE  = DEF_SETTLE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_BITS-1:0] in_op,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic [WIDTH-1:0]   op_a,
  output logic [WIDTH-1:0]   op_b,
  output logic [OP_BITS-1:0] mux_sel,
  input  logic [WIDTH-1:0]   mux_y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_result,
  output logic               out_erro,
  output logic               busy
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

  estado_t state, state_next;
  logic    accept, illegal, capture, cnt_zero, cnt_dec;

  assign in_ready  = (state == OCIOSO) && !rst;
  assign out_valid = (state == ENTREGA);
  assign busy      = (state != OCIOSO);

  assign accept  = in_ready && in_valid;
  assign illegal = (32'(in_op) >= 32'(NUM_OPS));
  assign capture = (state == ESPERA) && cnt_zero;
  assign cnt_dec = (state == ESPERA) && !cnt_zero;

  contador_espera u_contador (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (SETTLE_LOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_next = state;
    case (state)
      OCIOSO:  if (in_valid) state_next = illegal ? ENTREGA : ESPERA;
      ESPERA:  if (cnt_zero) state_next = ENTREGA;
      ENTREGA: if (out_ready) state_next = OCIOSO;
      default: state_next = OCIOSO;
    endcase
  end

  // op_a/op_b/mux_sel only load on accept, so they hold through ESPERA and
  // ENTREGA and keep their last values while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= OCIOSO;
      op_a       <= '0;
      op_b       <= '0;
      mux_sel    <= '0;
      out_result <= '0;
      out_erro   <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        op_a     <= in_a;
        op_b     <= in_b;
        mux_sel  <= in_op;
        out_erro <= illegal;
        if (illegal) out_result <= '0;
      end else if (capture) begin
        out_result <= mux_y;
      end
    end
  end

endmodule

// File: tb/tb_controle_ula.sv
// Directed bench for controle_ula: one instance with SETTLE=1/NUM_OPS=6 and
// one with SETTLE=4/NUM_OPS=8, sharing clock, reset and request data.
module tb_controle_ula;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] in_op = '0;
  logic [3:0] in_a = '0;
  logic [3:0] in_b = '0;
  logic       out_ready = 1'b0;

  logic       in_valid1 = 1'b0;
  logic       in_ready1, out_valid1, out_erro1, busy1;
  logic [3:0] op_a1, op_b1, out_result1, mux_y1;
  logic [2:0] mux_sel1;

  logic       in_valid4 = 1'b0;
  logic       in_ready4, out_valid4, out_erro4, busy4;
  logic [3:0] op_a4, op_b4, out_result4;
  logic [3:0] mux_y4 = '0;
  logic [2:0] mux_sel4;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  // Mux-tree model for the first instance: odd selects XOR, even selects ADD.
  assign mux_y1 = mux_sel1[0] ? (op_a1 ^ op_b1) : (op_a1 + op_b1);

  controle_ula #(.WIDTH(4), .OP_BITS(3), .NUM_OPS(6), .SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .op_a(op_a1), .op_b(op_b1), .mux_sel(mux_sel1), .mux_y(mux_y1),
    .out_valid(out_valid1), .out_ready(out_ready), .out_result(out_result1),
    .out_erro(out_erro1), .busy(busy1)
  );

  controle_ula #(.WIDTH(4), .OP_BITS(3), .NUM_OPS(8), .SETTLE(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .op_a(op_a4), .op_b(op_b4), .mux_sel(mux_sel4), .mux_y(mux_y4),
    .out_valid(out_valid4), .out_ready(out_ready), .out_result(out_result4),
    .out_erro(out_erro4), .busy(busy4)
  );

  task automatic test_reset();
    @(negedge clk);
    total++; if (in_ready1 !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", in_ready1); else passed++;
    total++; if (out_valid1 !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid1); else passed++;
    @(negedge clk);
    total++; if (busy1 !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy1); else passed++;
    total++; if ({op_a1, op_b1, mux_sel1} !== 11'd0) $display("FAIL rst_regs: got %h want 0", {op_a1, op_b1, mux_sel1}); else passed++;
    total++; if ({out_result1, out_erro1} !== 5'd0) $display("FAIL rst_result: got %h want 0", {out_result1, out_erro1}); else passed++;
    rst = 1'b0;
    #1;
    total++; if (in_ready1 !== 1'b1) $display("FAIL rst_release_ready: got %b want 1", in_ready1); else passed++;
  endtask

  task automatic test_reset_mid();
    bit saw_valid;
    @(negedge clk);
    in_valid4 = 1'b1; in_op = 3'd1; in_a = 4'h9; in_b = 4'h6;
    @(negedge clk);
    in_valid4 = 1'b0;
    total++; if (busy4 !== 1'b1) $display("FAIL mid_busy_before: got %b want 1", busy4); else passed++;
    rst = 1'b1;
    @(negedge clk);
    total++; if (in_ready4 !== 1'b0) $display("FAIL mid_ready_in_rst: got %b want 0", in_ready4); else passed++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (busy4 !== 1'b0) $display("FAIL mid_busy_after: got %b want 0", busy4); else passed++;
    total++; if (out_valid4 !== 1'b0) $display("FAIL mid_out_valid: got %b want 0", out_valid4); else passed++;
    total++; if ({op_a4, op_b4, mux_sel4} !== 11'd0) $display("FAIL mid_regs: got %h want 0", {op_a4, op_b4, mux_sel4}); else passed++;
    total++; if (in_ready4 !== 1'b1) $display("FAIL mid_in_ready: got %b want 1", in_ready4); else passed++;
    saw_valid = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid4 !== 1'b0) saw_valid = 1'b1;
    end
    total++; if (saw_valid !== 1'b0) $display("FAIL mid_stale_result: got %b want 0", saw_valid); else passed++;
  endtask

  task automatic test_basic();
    out_ready = 1'b0;
    @(negedge clk);
    in_valid1 = 1'b1; in_op = 3'd2; in_a = 4'h5; in_b = 4'h3;
    @(negedge clk);
    in_valid1 = 1'b0;
    total++; if (out_valid1 !== 1'b0) $display("FAIL basic_valid_early: got %b want 0", out_valid1); else passed++;
    total++; if ({op_a1, op_b1, mux_sel1} !== {4'h5, 4'h3, 3'd2}) $display("FAIL basic_regs: got %h want %h", {op_a1, op_b1, mux_sel1}, {4'h5, 4'h3, 3'd2}); else passed++;
    total++; if (in_ready1 !== 1'b0) $display("FAIL basic_in_ready: got %b want 0", in_ready1); else passed++;
    @(negedge clk);
    total++; if (out_valid1 !== 1'b1) $display("FAIL basic_valid: got %b want 1", out_valid1); else passed++;
    total++; if (out_result1 !== 4'h8) $display("FAIL basic_result: got %h want 8", out_result1); else passed++;
    total++; if (out_erro1 !== 1'b0) $display("FAIL basic_erro: got %b want 0", out_erro1); else passed++;
  endtask

  task automatic test_backpressure();
    in_valid1 = 1'b1; in_op = 3'd1; in_a = 4'h2; in_b = 4'h7;
    for (int unsigned i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if ({out_valid1, out_result1, in_ready1, op_a1} !== {1'b1, 4'h8, 1'b0, 4'h5}) $display("FAIL bp_hold_%0d: got %h want %h", i, {out_valid1, out_result1, in_ready1, op_a1}, {1'b1, 4'h8, 1'b0, 4'h5}); else passed++;
    end
    in_valid1 = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    total++; if ({out_valid1, busy1, in_ready1} !== 3'b001) $display("FAIL bp_release: got %b want 001", {out_valid1, busy1, in_ready1}); else passed++;
    total++; if ({op_a1, op_b1, mux_sel1} !== {4'h5, 4'h3, 3'd2}) $display("FAIL bp_regs_kept: got %h want %h", {op_a1, op_b1, mux_sel1}, {4'h5, 4'h3, 3'd2}); else passed++;
  endtask

  task automatic test_illegal();
    out_ready = 1'b0;
    @(negedge clk);
    in_valid1 = 1'b1; in_op = 3'd7; in_a = 4'h5; in_b = 4'h3;
    @(negedge clk);
    in_valid1 = 1'b0;
    total++; if ({out_valid1, out_result1, out_erro1} !== {1'b1, 4'h0, 1'b1}) $display("FAIL ill7: got %h want %h", {out_valid1, out_result1, out_erro1}, {1'b1, 4'h0, 1'b1}); else passed++;
    total++; if (mux_sel1 !== 3'd7) $display("FAIL ill7_sel: got %0d want 7", mux_sel1); else passed++;
    out_ready = 1'b1;
    @(negedge clk);
    total++; if (out_valid1 !== 1'b0) $display("FAIL ill7_done: got %b want 0", out_valid1); else passed++;
    // Opcode equal to NUM_OPS is the first illegal code.
    in_valid1 = 1'b1; in_op = 3'd6; in_a = 4'h1; in_b = 4'h1;
    @(negedge clk);
    in_valid1 = 1'b0;
    total++; if ({out_valid1, out_result1, out_erro1} !== {1'b1, 4'h0, 1'b1}) $display("FAIL ill6: got %h want %h", {out_valid1, out_result1, out_erro1}, {1'b1, 4'h0, 1'b1}); else passed++;
    @(negedge clk);
    in_valid1 = 1'b1; in_op = 3'd5; in_a = 4'h5; in_b = 4'h3;
    @(negedge clk);
    in_valid1 = 1'b0;
    total++; if (out_valid1 !== 1'b0) $display("FAIL legal5_early: got %b want 0", out_valid1); else passed++;
    @(negedge clk);
    total++; if ({out_valid1, out_result1, out_erro1} !== {1'b1, 4'h6, 1'b0}) $display("FAIL legal5: got %h want %h", {out_valid1, out_result1, out_erro1}, {1'b1, 4'h6, 1'b0}); else passed++;
    @(negedge clk);
  endtask

  task automatic test_settle4();
    logic [3:0] glitch [3] = '{4'h3, 4'hF, 4'h5};
    out_ready = 1'b0;
    @(negedge clk);
    in_valid4 = 1'b1; in_op = 3'd3; in_a = 4'h1; in_b = 4'h2;
    for (int unsigned c = 1; c <= 4; c++) begin
      @(negedge clk);
      in_valid4 = 1'b0;
      in_a = 4'(c + 7); in_b = 4'(c + 9); in_op = 3'(c);
      mux_y4 = (c == 4) ? 4'hA : glitch[c-1];
      total++; if ({op_a4, op_b4, mux_sel4, out_valid4} !== {4'h1, 4'h2, 3'd3, 1'b0}) $display("FAIL s4_hold_%0d: got %h want %h", c, {op_a4, op_b4, mux_sel4, out_valid4}, {4'h1, 4'h2, 3'd3, 1'b0}); else passed++;
    end
    @(negedge clk);
    mux_y4 = 4'h0;
    total++; if ({out_valid4, out_result4, out_erro4} !== {1'b1, 4'hA, 1'b0}) $display("FAIL s4_result: got %h want %h", {out_valid4, out_result4, out_erro4}, {1'b1, 4'hA, 1'b0}); else passed++;
    out_ready = 1'b1;
    @(negedge clk);
    total++; if (out_valid4 !== 1'b0) $display("FAIL s4_done: got %b want 0", out_valid4); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [2:0] ops  [3] = '{3'd2, 3'd1, 3'd4};
    logic [3:0] as   [3] = '{4'h1, 4'h6, 4'h7};
    logic [3:0] bs   [3] = '{4'h1, 4'h3, 4'h8};
    logic [3:0] exps [3] = '{4'h2, 4'h5, 4'hF};
    int acc_cyc [3];
    int n_acc = 0;
    int n_res = 0;
    bit acc, done;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid1 = 1'b1; in_op = ops[0]; in_a = as[0]; in_b = bs[0];
    for (int cyc = 0; cyc < 40 && n_res < 3; cyc++) begin
      acc  = in_ready1 && in_valid1;
      done = out_valid1 && out_ready;
      if (done) begin
        total++; if (out_result1 !== exps[n_res]) $display("FAIL b2b_result_%0d: got %h want %h", n_res, out_result1, exps[n_res]); else passed++;
        n_res++;
      end
      @(negedge clk);
      if (acc) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
        if (n_acc < 3) begin
          in_op = ops[n_acc]; in_a = as[n_acc]; in_b = bs[n_acc];
        end else begin
          in_valid1 = 1'b0;
        end
      end
    end
    total++; if (n_res != 3) $display("FAIL b2b_results: got %0d want 3", n_res); else passed++;
    total++; if (n_acc != 3) $display("FAIL b2b_accepts: got %0d want 3", n_acc); else passed++;
    if (n_acc == 3) begin
      total++; if (acc_cyc[1] - acc_cyc[0] != 3) $display("FAIL b2b_gap01: got %0d want 3", acc_cyc[1] - acc_cyc[0]); else passed++;
      total++; if (acc_cyc[2] - acc_cyc[1] != 3) $display("FAIL b2b_gap12: got %0d want 3", acc_cyc[2] - acc_cyc[1]); else passed++;
    end
    repeat (3) @(negedge clk);
    total++; if ({out_valid1, busy1} !== 2'b00) $display("FAIL b2b_idle: got %b want 00", {out_valid1, busy1}); else passed++;
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_basic();
    test_backpressure();
    test_illegal();
    test_settle4();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
